cla_slice_sequencer: RTL
========================

CLA_SLICE_SEQUENCER -- requirements
Module: cla_slice_sequencer

Interface
REQ-001 The block SHALL have parameter NBIT, default 4, giving the width of one CLA slice (same meaning as NBIT in constants.v).
REQ-002 The block SHALL have parameter NSLICE, default 4, giving the number of slices per wide operation; the wide width is W = NBIT*NSLICE.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning a wide operand pair is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts an operand pair this cycle.
REQ-007 The block SHALL have ports a and b, input, W each, the wide operands, and port c_in, input, 1, the carry-in.
REQ-008 The block SHALL have ports sl_a and sl_b, output, NBIT each, and port sl_cin, output, 1, the operands driven to the external slice adder.
REQ-009 The block SHALL have ports sl_sum, input, NBIT, and sl_cout, input, 1, the combinational (same-cycle) results of the slice adder.
REQ-010 The block SHALL have ports out_valid, output, 1; out_ready, input, 1; sum, output, W; c_out, output, 1, the result handshake.
REQ-011 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-012 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-013 In IDLE, in_ready SHALL be 1; in all other states in_ready SHALL be 0, and in_valid SHALL be ignored.
REQ-014 On in_valid && in_ready, the block SHALL latch a, b and c_in, clear the slice counter to 0, and enter RUN.
REQ-015 In RUN, the block SHALL drive slice k of the latched operands on sl_a/sl_b, where k is the counter value and slice k is bits [k*NBIT+NBIT-1 : k*NBIT].
REQ-016 In RUN, sl_cin SHALL equal the latched c_in for k=0; for k>0 it SHALL equal the sl_cout captured in the previous cycle.
REQ-017 Each RUN cycle, the block SHALL write sl_sum into result bits for slice k, register sl_cout, and increment k.
REQ-018 When k = NSLICE-1 in RUN, the block SHALL capture the final sl_cout into c_out and enter DONE at the next edge.
REQ-019 The latency SHALL be exactly NSLICE+1 cycles from the accept edge to the first edge at which out_valid is sampled high, absent reset.
REQ-020 In DONE, out_valid SHALL be 1, sum and c_out SHALL be stable, and the block SHALL hold until out_valid && out_ready, then return to IDLE.
REQ-021 A new operand pair SHALL NOT be accepted in the cycle DONE is exiting; the earliest next accept is the following cycle.
REQ-022 Outside RUN, sl_a, sl_b and sl_cin SHALL be driven to 0.
REQ-023 The addition SHALL be unsigned modulo 2^W, with c_out the carry out of bit W-1; wrap-around is reported only through c_out.
REQ-024 The slice counter SHALL be ceil(log2(NSLICE)) bits wide, minimum 1, and SHALL never exceed NSLICE-1.
REQ-025 When NSLICE=1, RUN SHALL last exactly one cycle.

Reset
REQ-026 While rst=1 at a rising edge, the FSM SHALL go to IDLE, the counter and carry register SHALL clear, sum SHALL be 0, c_out SHALL be 0 and out_valid SHALL be 0.
REQ-027 Reset SHALL take priority over any handshake in the same cycle; an operation in RUN or DONE SHALL be discarded with no out_valid.
REQ-028 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Verification (NBIT=4, NSLICE=4, W=16)
REQ-029 Stimulus: a=0x0002, b=0x0003, c_in=0, out_ready=1. Required response: out_valid after 5 cycles, sum=0x0005, c_out=0.
REQ-030 Stimulus: a=0xFFFF, b=0x0001, c_in=0. Required response: sum=0x0000, c_out=1, with the carry rippling through all 4 slices; sl_cin must read 0,1,1,1 across the RUN cycles.
REQ-031 Stimulus: a=0x8000, b=0x8000, c_in=1. Required response: sum=0x0001, c_out=1.
REQ-032 Stimulus: out_ready held at 0 for 3 cycles in DONE, while in_valid is pulsed with new operands. Required response: out_valid stays 1, sum is stable, the new operands are not accepted, and the block returns to IDLE on the cycle out_ready rises.
REQ-033 Stimulus: rst asserted while k=2 in RUN. Required response: IDLE next cycle, out_valid never asserts for that operation, and a following a=0x0005, b=0x000A operation yields sum=0x000F.
REQ-034 Stimulus: back-to-back operations with in_valid held high. Required response: each accepted one cycle after its predecessor's DONE exit, and results match a 16-bit reference model for 1000 random operand pairs.

Source files
------------

// File: rtl/cla_slice_sequencer_if.sv
// Handshake and slice-adder bus between the wide-add sequencer and its environment.
// The slave modport is the sequencer; the master modport is the operand source, result sink and slice adder.
interface cla_slice_sequencer_if #(
   parameter int NBIT   = 4,
   parameter int NSLICE = 4
);
   localparam int W = NBIT * NSLICE;

   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic            c_in;
   logic [NBIT-1:0] sl_a;
   logic [NBIT-1:0] sl_b;
   logic            sl_cin;
   logic [NBIT-1:0] sl_sum;
   logic            sl_cout;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    sum;
   logic            c_out;
   logic            busy;

   modport slave (
      input  in_valid, a, b, c_in, sl_sum, sl_cout, out_ready,
      output in_ready, sl_a, sl_b, sl_cin, out_valid, sum, c_out, busy
   );

   modport master (
      output in_valid, a, b, c_in, sl_sum, sl_cout, out_ready,
      input  in_ready, sl_a, sl_b, sl_cin, out_valid, sum, c_out, busy
   );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Performs a W-bit unsigned add by stepping one NBIT slice per cycle through an external
// combinational slice adder, rippling the carry between slices through a register.
module cla_slice_sequencer #(
   parameter int NBIT   = 4,
   parameter int NSLICE = 4
) (
   input logic                    clk,
   input logic                    rst,
   cla_slice_sequencer_if.slave   bus
);
   localparam int W  = NBIT * NSLICE;
   localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            cin_q, cin_d;
   logic            carry_q, carry_d;
   logic            c_out_q, c_out_d;
   logic [KW-1:0]   k_q, k_d;
   logic [NBIT-1:0] sl_a_s, sl_b_s;
   logic            sl_cin_s;

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cin_q   <= cin_d;
         carry_q <= carry_d;
         c_out_q <= c_out_d;
         k_q     <= k_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cin_d   = cin_q;
      carry_d = carry_q;
      c_out_d = c_out_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               cin_d   = bus.c_in;
               sum_d   = '0;
               carry_d = 1'b0;
               c_out_d = 1'b0;
               k_d     = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[NBIT*int'(k_q) +: NBIT] = bus.sl_sum;
            carry_d = bus.sl_cout;
            // Counter stops at the last slice so it never exceeds NSLICE-1.
            if (k_q == K_LAST) begin
               c_out_d = bus.sl_cout;
               state_d = DONE;
            end else begin
               k_d     = k_q + KW'(1);
               state_d = RUN;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Slice operand mux toward the external adder; quiet outside RUN.
   always_comb begin
      sl_a_s   = '0;
      sl_b_s   = '0;
      sl_cin_s = 1'b0;
      if (state_q == RUN) begin
         sl_a_s   = a_q[NBIT*int'(k_q) +: NBIT];
         sl_b_s   = b_q[NBIT*int'(k_q) +: NBIT];
         sl_cin_s = (k_q == '0) ? cin_q : carry_q;
      end else begin
         sl_a_s   = '0;
         sl_b_s   = '0;
         sl_cin_s = 1'b0;
      end
   end

   assign bus.sl_a      = sl_a_s;
   assign bus.sl_b      = sl_b_s;
   assign bus.sl_cin    = sl_cin_s;
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.c_out     = c_out_q;
endmodule
